// File: rtl/div_sched.sv
// Iterative divider sequencer: LOAD -> STEPS x RUN -> WRITE, with the HiLo pipeline interlock.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor skips RUN and flags dz_err instead of writing HiLo.
module div_sched #(
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_req,
    input  logic          divisor_zero,
    input  logic          mf_req,
    output logic          div_load,
    output logic          div_step,
    output logic [CW-1:0] step_idx,
    output logic          hilo_we,
    output logic          done,
    output logic          dz_err,
    output logic          busy,
    output logic          stall
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        WRITE
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          load_zero;
    logic          zero_wr;

`ifdef DIV_ZERO_TRAP_EN
    // Remembers whether the divide in flight is the zero-divisor shortcut.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_wr <= 1'b0;
        end else if (state == LOAD) begin
            zero_wr <= divisor_zero;
        end
    end

    assign load_zero = divisor_zero;
`else
    logic unused_divisor_zero;

    assign unused_divisor_zero = divisor_zero;
    assign load_zero           = 1'b0;
    assign zero_wr             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        div_load  = 1'b0;
        div_step  = 1'b0;
        step_idx  = '0;
        hilo_we   = 1'b0;
        done      = 1'b0;
        dz_err    = 1'b0;
        busy      = 1'b0;
        stall     = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                if (div_req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                div_load  = 1'b1;
                count_nxt = '0;
                state_nxt = load_zero ? WRITE : RUN;
            end
            RUN: begin
                div_step = 1'b1;
                step_idx = count;
                if (count == LAST_STEP) begin
                    count_nxt = '0;
                    state_nxt = WRITE;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            WRITE: begin
                done      = 1'b1;
                hilo_we   = ~zero_wr;
                dz_err    = zero_wr;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        busy  = (state != IDLE);
        stall = busy & (div_req | mf_req);

        // A reset cycle silences everything so an aborted divide can never leak a write.
        if (rst) begin
            div_load = 1'b0;
            div_step = 1'b0;
            step_idx = '0;
            hilo_we  = 1'b0;
            done     = 1'b0;
            dz_err   = 1'b0;
            busy     = 1'b0;
            stall    = 1'b0;
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed table, hand-written corner sequences,
// and a randomized run against a cycle-position reference model.
module tb_div_sched;

    localparam int STEPS = 32;
    localparam int CW    = 6;

`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          div_req;
    logic          divisor_zero;
    logic          mf_req;
    logic          div_load;
    logic          div_step;
    logic [CW-1:0] step_idx;
    logic          hilo_we;
    logic          done;
    logic          dz_err;
    logic          busy;
    logic          stall;

    always #5 clk = ~clk;

    div_sched #(.STEPS(STEPS), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .divisor_zero (divisor_zero),
        .mf_req       (mf_req),
        .div_load     (div_load),
        .div_step     (div_step),
        .step_idx     (step_idx),
        .hilo_we      (hilo_we),
        .done         (done),
        .dz_err       (dz_err),
        .busy         (busy),
        .stall        (stall)
    );

    typedef struct packed {
        logic          load;
        logic          step;
        logic [CW-1:0] idx;
        logic          we;
        logic          done;
        logic          dzerr;
        logic          busy;
        logic          stall;
    } outs_t;

    typedef struct {
        logic  req;
        logic  mf;
        int    n;
        outs_t exp;
        bit    idx_inc;
    } vec_t;

    outs_t act;
    outs_t mexp;
    int    total = 0;
    int    bad   = 0;

    // Reference model: position inside the current divide (0 = idle, 1 = load,
    // 2..STEPS+1 = iterations, STEPS+2 = write) plus the zero-divisor flag.
    int    pos   = 0;
    bit    zflag = 1'b0;

    function automatic outs_t mkOut(input logic l, input logic s, input int i, input logic w,
                                    input logic d, input logic z, input logic b, input logic st);
        outs_t o;
        o.load  = l;
        o.step  = s;
        o.idx   = CW'(i);
        o.we    = w;
        o.done  = d;
        o.dzerr = z;
        o.busy  = b;
        o.stall = st;
        return o;
    endfunction

    function automatic outs_t modelOut();
        outs_t o;
        bit    wr;
        o  = '0;
        wr = (pos == STEPS + 2);
        if (!rst) begin
            o.busy  = (pos != 0);
            o.load  = (pos == 1);
            o.step  = (pos >= 2) && (pos <= STEPS + 1);
            o.idx   = o.step ? CW'(pos - 2) : '0;
            o.done  = wr;
            o.we    = wr && !zflag;
            o.dzerr = wr && zflag;
            o.stall = o.busy && (div_req || mf_req);
        end
        return o;
    endfunction

    task automatic modelStep();
        if (rst) begin
            pos   = 0;
            zflag = 1'b0;
        end else if (pos == 0) begin
            if (div_req) pos = 1;
        end else if (pos == 1) begin
            zflag = TRAP && divisor_zero;
            pos   = zflag ? STEPS + 2 : 2;
        end else if (pos == STEPS + 2) begin
            pos   = 0;
            zflag = 1'b0;
        end else begin
            pos = pos + 1;
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, advance the model at the edge.
    task automatic applyStimulus(input logic r, input logic q, input logic z, input logic m);
        rst          = r;
        div_req      = q;
        divisor_zero = z;
        mf_req       = m;
        @(negedge clk);
        act.load  = div_load;
        act.step  = div_step;
        act.idx   = step_idx;
        act.we    = hilo_we;
        act.done  = done;
        act.dzerr = dz_err;
        act.busy  = busy;
        act.stall = stall;
        mexp      = modelOut();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, actual, expected);
        end
    endtask

    vec_t tbl[7];

    initial begin
        outs_t e;

        // Reset state, with div_req asserted to show reset wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_outs", act, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_outs2", act, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_idle", act, '0);

        // Basic divide with HiLo read held from cycle 10.
        tbl[0] = '{1'b1, 1'b0, 1,  mkOut(0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1,  mkOut(1, 0, 0, 0, 0, 0, 1, 0), 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8,  mkOut(0, 1, 0, 0, 0, 0, 1, 0), 1'b1};
        tbl[3] = '{1'b0, 1'b1, 24, mkOut(0, 1, 8, 0, 0, 0, 1, 1), 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1,  mkOut(0, 0, 0, 1, 1, 0, 1, 1), 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1,  mkOut(0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2,  mkOut(0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                e = tbl[r].exp;
                if (tbl[r].idx_inc) e.idx = e.idx + CW'(k);
                applyStimulus(1'b0, tbl[r].req, 1'b0, tbl[r].mf);
                checkOutput($sformatf("table_r%0d_k%0d", r, k), act, e);
            end
        end

        // Back-to-back: second request held from cycle 20 until accepted at the idle edge.
        for (int c = 0; c <= 75; c++) begin
            applyStimulus(1'b0, (c == 0) || (c >= 20 && c <= 35), 1'b0, 1'b0);
            if (c >= 20 && c <= 34) checkOutput("b2b_stall", act.stall, 1'b1);
            if (c == 35) checkOutput("b2b_idle_gap", {act.busy, act.stall}, 2'b00);
            checkOutput("b2b_load", act.load, (c == 1) || (c == 36));
            checkOutput("b2b_hilo_we", act.we, (c == 34) || (c == STEPS + 37));
        end

        // Reset mid-run, with a colliding request in the reset cycle.
        for (int c = 0; c <= 60; c++) begin
            applyStimulus(c == 15, (c == 0) || (c == 15), 1'b0, (c >= 14 && c <= 20));
            if (c == 14) checkOutput("rst_pre_stall", act.stall, 1'b1);
            if (c == 15) checkOutput("rst_cycle_outs", act, '0);
            if (c == 16) checkOutput("rst_after", {act.busy, act.stall, act.idx}, '0);
            if (c >= 16) checkOutput("rst_no_write", {act.we, act.done, act.load}, 3'b000);
        end

        // Zero divisor, held for the whole divide.
        for (int c = 0; c <= 40; c++) begin
            applyStimulus(1'b0, c == 0, 1'b1, 1'b0);
            checkOutput("dz_load", act.load, c == 1);
`ifdef DIV_ZERO_TRAP_EN
            checkOutput("dz_trap_flag", {act.dzerr, act.done, act.we}, (c == 2) ? 3'b110 : 3'b000);
            checkOutput("dz_trap_busy", act.busy, (c == 1) || (c == 2));
`else
            checkOutput("dz_ignored_flag", {act.dzerr, act.done, act.we}, (c == 34) ? 3'b011 : 3'b000);
            checkOutput("dz_ignored_busy", act.busy, (c >= 1) && (c <= 34));
`endif
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(199) == 0), ($urandom_range(5) == 0),
                          $urandom_range(1), ($urandom_range(3) == 0));
            checkOutput($sformatf("random_c%0d", c), act, mexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
